button_cfg_ctrl: RTL and testbench

Front-panel configuration controller for the camera/IPM pipeline. Takes three already-debounced push-button levels (up, down, select) and turns them into configuration state: a display/processing mode index and a saturating tuning value such as an IPM tilt offset. Adds edge detection, press-and-hold auto-repeat, and long-press restore-default. Emits a one-cycle update strobe so downstream blocks latch the new configuration.

---
 rtl/button_cfg_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_button_cfg_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_cfg_ctrl.sv
// Front-panel configuration controller: three debounced buttons drive a
// wrapping mode index and a saturating tuning value with auto-repeat and long-press restore.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   i_btn_up     debounced level, 1 = pressed
//   i_btn_down   debounced level, 1 = pressed
//   i_btn_sel    debounced level, 1 = pressed
//   o_mode       current mode index (wraps N_MODES-1 -> 0)
//   o_value      current tuning value (saturates at VAL_MIN / VAL_MAX)
//   o_cfg_update one-cycle pulse when o_mode or o_value changes
//   o_busy       high whenever the FSM is not IDLE
module button_cfg_ctrl #(
  parameter int N_MODES       = 4,
  parameter int MODE_W        = 2,
  parameter int VAL_W         = 8,
  parameter int VAL_MIN       = 0,
  parameter int VAL_MAX       = 255,
  parameter int VAL_DEFAULT   = 128,
  parameter int HOLD_CYCLES   = 12500000,
  parameter int REPEAT_CYCLES = 2500000,
  parameter int CNT_W         = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_btn_up,
  input  logic              i_btn_down,
  input  logic              i_btn_sel,
  output logic [MODE_W-1:0] o_mode,
  output logic [VAL_W-1:0]  o_value,
  output logic              o_cfg_update,
  output logic              o_busy
);

  localparam logic [VAL_W-1:0]  VMIN = VAL_W'(VAL_MIN);
  localparam logic [VAL_W-1:0]  VMAX = VAL_W'(VAL_MAX);
  localparam logic [VAL_W-1:0]  VDEF = VAL_W'(VAL_DEFAULT);
  localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(N_MODES - 1);
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_REPEAT,
    S_SEL_HOLD,
    S_WAIT_REL
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic [VAL_W-1:0]  value_q, value_d;
  logic              upd_q, upd_d;
  logic              cap_up_q, cap_up_d;
  logic              up_prev_q, dn_prev_q, sel_prev_q;

  logic              up_edge, dn_edge, sel_edge;
  logic              cap_lvl;
  logic              inc_ok, dec_ok;
  logic [VAL_W-1:0]  val_inc, val_dec;
  logic [MODE_W-1:0] mode_next;

  // Previous-level registers reset to 1 so a button held through reset
  // must be released and pressed again before it counts.
  assign up_edge  = i_btn_up   & ~up_prev_q;
  assign dn_edge  = i_btn_down & ~dn_prev_q;
  assign sel_edge = i_btn_sel  & ~sel_prev_q;

  assign cap_lvl = cap_up_q ? i_btn_up : i_btn_down;

  assign inc_ok  = (value_q < VMAX);
  assign dec_ok  = (value_q > VMIN);
  assign val_inc = inc_ok ? value_q + 1'b1 : value_q;
  assign val_dec = dec_ok ? value_q - 1'b1 : value_q;

  assign mode_next = (mode_q == MODE_LAST) ? '0 : mode_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    value_d  = value_q;
    cap_up_d = cap_up_q;
    upd_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Priority sel > up > down; losers of the same cycle are dropped.
        if (sel_edge) begin
          mode_d  = mode_next;
          upd_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_SEL_HOLD;
        end else if (up_edge) begin
          cap_up_d = 1'b1;
          value_d  = val_inc;
          upd_d    = inc_ok;
          cnt_d    = '0;
          state_d  = S_HOLD;
        end else if (dn_edge) begin
          cap_up_d = 1'b0;
          value_d  = val_dec;
          upd_d    = dec_ok;
          cnt_d    = '0;
          state_d  = S_HOLD;
        end
      end

      S_HOLD: begin
        if (!cap_lvl) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == HOLD_LAST) begin
          value_d = cap_up_q ? val_inc : val_dec;
          upd_d   = cap_up_q ? inc_ok : dec_ok;
          cnt_d   = '0;
          state_d = S_REPEAT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_REPEAT: begin
        if (!cap_lvl) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == REP_LAST) begin
          value_d = cap_up_q ? val_inc : val_dec;
          upd_d   = cap_up_q ? inc_ok : dec_ok;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_SEL_HOLD: begin
        if (!i_btn_sel) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == HOLD_LAST) begin
          // Long press restores the default value; mode stays put.
          value_d = VDEF;
          upd_d   = (value_q != VDEF);
          cnt_d   = '0;
          state_d = S_WAIT_REL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WAIT_REL: begin
        if (!i_btn_sel) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      mode_q     <= '0;
      value_q    <= VDEF;
      upd_q      <= 1'b0;
      cap_up_q   <= 1'b0;
      up_prev_q  <= 1'b1;
      dn_prev_q  <= 1'b1;
      sel_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      value_q    <= value_d;
      upd_q      <= upd_d;
      cap_up_q   <= cap_up_d;
      up_prev_q  <= i_btn_up;
      dn_prev_q  <= i_btn_down;
      sel_prev_q <= i_btn_sel;
    end
  end

  assign o_mode       = mode_q;
  assign o_value      = value_q;
  assign o_cfg_update = upd_q;
  assign o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_button_cfg_ctrl.sv
// Bench for button_cfg_ctrl: per-cycle vector table plus
// hand-written auto-repeat, saturation, long-press and reset sequences.
module tb_button_cfg_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       up = 1'b0;
  logic       dn = 1'b0;
  logic       sel = 1'b0;
  logic [1:0] mode;
  logic [3:0] value;
  logic       upd;
  logic       busy;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  button_cfg_ctrl #(
    .N_MODES(3),
    .MODE_W(2),
    .VAL_W(4),
    .VAL_MIN(0),
    .VAL_MAX(15),
    .VAL_DEFAULT(8),
    .HOLD_CYCLES(10),
    .REPEAT_CYCLES(4),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_btn_up(up),
    .i_btn_down(dn),
    .i_btn_sel(sel),
    .o_mode(mode),
    .o_value(value),
    .o_cfg_update(upd),
    .o_busy(busy)
  );

  typedef struct {
    logic [3:0] in;
    logic [1:0] mode;
    logic [3:0] val;
    logic       upd;
    logic       busy;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(input logic [3:0] in, input logic [1:0] m,
                              input logic [3:0] v, input logic p,
                              input logic b);
    vec_t r;
    r.in = in;
    r.mode = m;
    r.val = v;
    r.upd = p;
    r.busy = b;
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // One clock: inputs applied after the previous edge, outputs sampled 1 ns
  // after this edge.
  task automatic cyc(input logic r, input logic u, input logic d,
                     input logic s);
    reset = r;
    up = u;
    dn = d;
    sel = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int pulses;
    logic e_upd;

    // in = {reset, up, down, sel}
    tbl[0]  = mk(4'b1000, 2'd0, 4'd8,  1'b0, 1'b0);
    tbl[1]  = mk(4'b0000, 2'd0, 4'd8,  1'b0, 1'b0);
    tbl[2]  = mk(4'b0100, 2'd0, 4'd9,  1'b1, 1'b1);
    tbl[3]  = mk(4'b0100, 2'd0, 4'd9,  1'b0, 1'b1);
    tbl[4]  = mk(4'b0100, 2'd0, 4'd9,  1'b0, 1'b1);
    tbl[5]  = mk(4'b0000, 2'd0, 4'd9,  1'b0, 1'b0);
    tbl[6]  = mk(4'b0000, 2'd0, 4'd9,  1'b0, 1'b0);
    tbl[7]  = mk(4'b0110, 2'd0, 4'd10, 1'b1, 1'b1);
    tbl[8]  = mk(4'b0000, 2'd0, 4'd10, 1'b0, 1'b0);
    tbl[9]  = mk(4'b0101, 2'd1, 4'd10, 1'b1, 1'b1);
    tbl[10] = mk(4'b0000, 2'd1, 4'd10, 1'b0, 1'b0);
    tbl[11] = mk(4'b0010, 2'd1, 4'd9,  1'b1, 1'b1);
    tbl[12] = mk(4'b0100, 2'd1, 4'd9,  1'b0, 1'b0);
    tbl[13] = mk(4'b0100, 2'd1, 4'd9,  1'b0, 1'b0);
    tbl[14] = mk(4'b0000, 2'd1, 4'd9,  1'b0, 1'b0);
    tbl[15] = mk(4'b1100, 2'd0, 4'd8,  1'b0, 1'b0);
    tbl[16] = mk(4'b0100, 2'd0, 4'd8,  1'b0, 1'b0);
    tbl[17] = mk(4'b0000, 2'd0, 4'd8,  1'b0, 1'b0);
    tbl[18] = mk(4'b0100, 2'd0, 4'd9,  1'b1, 1'b1);
    tbl[19] = mk(4'b0000, 2'd0, 4'd9,  1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      cyc(tbl[i].in[3], tbl[i].in[2], tbl[i].in[1], tbl[i].in[0]);
      chk($sformatf("vec%0d_mode", i), int'(mode), int'(tbl[i].mode));
      chk($sformatf("vec%0d_val", i), int'(value), int'(tbl[i].val));
      chk($sformatf("vec%0d_upd", i), int'(upd), int'(tbl[i].upd));
      chk($sformatf("vec%0d_busy", i), int'(busy), int'(tbl[i].busy));
    end

    // Auto-repeat: steps at relative cycles 0, 10, 14, 18, 22, 26.
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    for (int r = 0; r < 28; r++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      n = 1 + ((r >= 10) ? 1 + (r - 10) / 4 : 0);
      e_upd = (r == 0) || (r >= 10 && ((r - 10) % 4) == 0);
      chk($sformatf("rep%0d_val", r), int'(value), 8 + n);
      chk($sformatf("rep%0d_upd", r), int'(upd), int'(e_upd));
      chk($sformatf("rep%0d_busy", r), int'(busy), 1);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rep_rel_busy", int'(busy), 0);
    chk("rep_rel_val", int'(value), 14);
    chk("rep_rel_upd", int'(upd), 0);

    // Saturation at the top.
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("top_up_val", int'(value), 15);
    chk("top_up_upd", int'(upd), 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("sat_up_val", int'(value), 15);
    chk("sat_up_upd", int'(upd), 0);
    chk("sat_up_busy", int'(busy), 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("sat_dn_val", int'(value), 14);
    chk("sat_dn_upd", int'(upd), 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Saturation at the bottom.
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      chk($sformatf("down%0d_val", i), int'(value), 7 - i);
      chk($sformatf("down%0d_upd", i), int'(upd), 1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("sat_lo_val", int'(value), 0);
    chk("sat_lo_upd", int'(upd), 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("lo_up_val", int'(value), 1);
    chk("lo_up_upd", int'(upd), 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Mode wrap with three sel taps.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chk($sformatf("sel%0d_mode", i), int'(mode), (i + 1) % 3);
      chk($sformatf("sel%0d_upd", i), int'(upd), 1);
      chk($sformatf("sel%0d_val", i), int'(value), 1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("pre_long_val", int'(value), 3);

    // Long press on sel: mode +1 at the press, default value at cycle 10.
    for (int r = 0; r < 15; r++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chk($sformatf("long%0d_mode", r), int'(mode), 1);
      chk($sformatf("long%0d_val", r), int'(value), (r < 10) ? 3 : 8);
      chk($sformatf("long%0d_upd", r), int'(upd),
          (r == 0 || r == 10) ? 1 : 0);
      chk($sformatf("long%0d_busy", r), int'(busy), 1);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("long_rel_busy", int'(busy), 0);
    chk("long_rel_mode", int'(mode), 1);
    chk("long_rel_val", int'(value), 8);

    // Reset in the middle of REPEAT with up still held.
    for (int r = 0; r < 12; r++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("mid_rep_val", int'(value), 10);
    chk("mid_rep_busy", int'(busy), 1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("rst_mode", int'(mode), 0);
    chk("rst_val", int'(value), 8);
    chk("rst_upd", int'(upd), 0);
    chk("rst_busy", int'(busy), 0);
    pulses = 0;
    for (int r = 0; r < 15; r++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      if (upd) pulses++;
    end
    chk("held_pulses", pulses, 0);
    chk("held_val", int'(value), 8);
    chk("held_busy", int'(busy), 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("repress_val", int'(value), 9);
    chk("repress_upd", int'(upd), 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
